// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller.
// Walks a byte-address PC through an instruction ROM, buffers fetched
// {pc, inst} pairs in a small FIFO for the decode stage, and handles
// branch redirects (flushing the buffer) and misaligned redirect targets.

module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target_addr,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        misalign_err
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    ERR
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic [31:0]   buf_inst [BUF_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          pop;
  logic          push;
  logic          redirect;
  logic          buf_full;
  logic [CW-1:0] count_after_pop;

  // Handshake decode: what moves through the buffer this cycle
  always_comb begin
    redirect        = branch_flag && (state != IDLE);
    pop             = if_valid && if_ready;
    buf_full        = (count == FULL_COUNT);
    push            = (state == FETCH) && !stall && !branch_flag &&
                      (!buf_full || pop);
    count_after_pop = count - CW'(pop);
  end

  // ROM port and buffer-head presentation, decoded from registered state
  always_comb begin
    rom_ce   = (state == FETCH) || (state == HOLD);
    rom_addr = rom_ce ? pc : 32'h0;
    if_valid = (count != '0);
    if_pc    = if_valid ? buf_pc[rd_ptr]   : 32'h0;
    if_inst  = if_valid ? buf_inst[rd_ptr] : 32'h0;
  end

  // Fetch FSM, PC, and FIFO storage; a redirect overrides every other update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]   <= 32'h0;
        buf_inst[i] <= 32'h0;
      end
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pc     <= branch_target_addr;
      if (branch_target_addr[1:0] == 2'b00) begin
        state        <= FETCH;
        misalign_err <= 1'b0;
      end else begin
        state        <= ERR;
        misalign_err <= 1'b1;
      end
    end else begin
      if (push) begin
        buf_pc[wr_ptr]   <= pc;
        buf_inst[wr_ptr] <= rom_inst;
        wr_ptr           <= wr_ptr + PW'(1);
        pc               <= pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);

      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (stall || (buf_full && !pop)) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!stall && (count_after_pop < FULL_COUNT)) begin
            state <= FETCH;
          end
        end
        ERR: begin
          state <= ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed testbench for inst_fetch_ctrl.
// The ROM model returns word n at byte address 4n. A second instance with
// RESET_PC near the top of the address space exercises PC wrap-around.

module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target_addr;
  logic        if_ready;

  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        misalign_err;

  logic        w_rom_ce;
  logic [31:0] w_rom_addr;
  logic [31:0] w_rom_inst;
  logic        w_if_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_inst;
  logic        w_misalign_err;

  int total;
  int bad;

  assign rom_inst   = {2'b00, rom_addr[31:2]};
  assign w_rom_inst = {2'b00, w_rom_addr[31:2]};

  inst_fetch_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .branch_flag        (branch_flag),
    .branch_target_addr (branch_target_addr),
    .rom_ce             (rom_ce),
    .rom_addr           (rom_addr),
    .rom_inst           (rom_inst),
    .if_valid           (if_valid),
    .if_ready           (if_ready),
    .if_pc              (if_pc),
    .if_inst            (if_inst),
    .misalign_err       (misalign_err)
  );

  inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_wrap (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .branch_flag        (branch_flag),
    .branch_target_addr (branch_target_addr),
    .rom_ce             (w_rom_ce),
    .rom_addr           (w_rom_addr),
    .rom_inst           (w_rom_inst),
    .if_valid           (w_if_valid),
    .if_ready           (if_ready),
    .if_pc              (w_if_pc),
    .if_inst            (w_if_inst),
    .misalign_err       (w_misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Put the DUT into HOLD with two buffered entries (pc 0 and 4), pc = 8
  task automatic fill_to_hold();
    rst      = 1'b0;
    stall    = 1'b0;
    branch_flag = 1'b0;
    if_ready = 1'b0;
    tick();
    rst = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    stall = 1'b0;
    branch_flag = 1'b0;
    branch_target_addr = 32'h0;
    if_ready = 1'b0;
    #3;
    total++; if (rom_ce !== 1'b0) begin bad++; $display("[TB] FAIL reset_rom_ce got=%h exp=%h", rom_ce, 1'b0); end
    total++; if (rom_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_rom_addr got=%h exp=%h", rom_addr, 32'h0); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_if_valid got=%h exp=%h", if_valid, 1'b0); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_if_pc got=%h exp=%h", if_pc, 32'h0); end
    total++; if (if_inst !== 32'h0) begin bad++; $display("[TB] FAIL reset_if_inst got=%h exp=%h", if_inst, 32'h0); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_misalign got=%h exp=%h", misalign_err, 1'b0); end
  endtask

  task automatic test_free_run();
    rst = 1'b0;
    if_ready = 1'b1;
    tick();
    rst = 1'b1;
    total++; if (rom_ce !== 1'b0) begin bad++; $display("[TB] FAIL free_idle_rom_ce got=%h exp=%h", rom_ce, 1'b0); end
    tick();
    total++; if (rom_ce !== 1'b1) begin bad++; $display("[TB] FAIL free_first_rom_ce got=%h exp=%h", rom_ce, 1'b1); end
    total++; if (rom_addr !== 32'h0) begin bad++; $display("[TB] FAIL free_first_rom_addr got=%h exp=%h", rom_addr, 32'h0); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL free_first_if_valid got=%h exp=%h", if_valid, 1'b0); end
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (if_valid !== 1'b1) begin bad++; $display("[TB] FAIL free_valid[%0d] got=%h exp=%h", k, if_valid, 1'b1); end
      total++; if (if_pc !== 32'(4 * k)) begin bad++; $display("[TB] FAIL free_pc[%0d] got=%h exp=%h", k, if_pc, 32'(4 * k)); end
      total++; if (if_inst !== 32'(k)) begin bad++; $display("[TB] FAIL free_inst[%0d] got=%h exp=%h", k, if_inst, 32'(k)); end
    end
  endtask

  task automatic test_backpressure();
    fill_to_hold();
    tick();
    total++; if (rom_ce !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_rom_ce got=%h exp=%h", rom_ce, 1'b1); end
    total++; if (rom_addr !== 32'h8) begin bad++; $display("[TB] FAIL bp_hold_pc got=%h exp=%h", rom_addr, 32'h8); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("[TB] FAIL bp_hold_head got=%h exp=%h", if_pc, 32'h0); end
    if_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (if_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid[%0d] got=%h exp=%h", k, if_valid, 1'b1); end
      total++; if (if_pc !== 32'(4 * k)) begin bad++; $display("[TB] FAIL bp_pc[%0d] got=%h exp=%h", k, if_pc, 32'(4 * k)); end
      total++; if (if_inst !== 32'(k)) begin bad++; $display("[TB] FAIL bp_inst[%0d] got=%h exp=%h", k, if_inst, 32'(k)); end
      tick();
    end
  endtask

  task automatic test_redirect();
    fill_to_hold();
    if_ready = 1'b1;
    branch_flag = 1'b1;
    branch_target_addr = 32'h0000_0100;
    tick();
    branch_flag = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_flush_valid got=%h exp=%h", if_valid, 1'b0); end
    total++; if (rom_addr !== 32'h100) begin bad++; $display("[TB] FAIL redir_rom_addr got=%h exp=%h", rom_addr, 32'h100); end
    total++; if (rom_ce !== 1'b1) begin bad++; $display("[TB] FAIL redir_rom_ce got=%h exp=%h", rom_ce, 1'b1); end
    tick();
    total++; if (if_valid !== 1'b1) begin bad++; $display("[TB] FAIL redir_valid got=%h exp=%h", if_valid, 1'b1); end
    total++; if (if_pc !== 32'h100) begin bad++; $display("[TB] FAIL redir_pc0 got=%h exp=%h", if_pc, 32'h100); end
    total++; if (if_inst !== 32'h40) begin bad++; $display("[TB] FAIL redir_inst0 got=%h exp=%h", if_inst, 32'h40); end
    tick();
    total++; if (if_pc !== 32'h104) begin bad++; $display("[TB] FAIL redir_pc1 got=%h exp=%h", if_pc, 32'h104); end
    total++; if (if_inst !== 32'h41) begin bad++; $display("[TB] FAIL redir_inst1 got=%h exp=%h", if_inst, 32'h41); end
  endtask

  task automatic test_misalign();
    branch_flag = 1'b1;
    branch_target_addr = 32'h0000_0102;
    tick();
    branch_flag = 1'b0;
    for (int r = 0; r < 3; r++) begin
      total++; if (misalign_err !== 1'b1) begin bad++; $display("[TB] FAIL mis_flag[%0d] got=%h exp=%h", r, misalign_err, 1'b1); end
      total++; if (rom_ce !== 1'b0) begin bad++; $display("[TB] FAIL mis_rom_ce[%0d] got=%h exp=%h", r, rom_ce, 1'b0); end
      total++; if (rom_addr !== 32'h0) begin bad++; $display("[TB] FAIL mis_rom_addr[%0d] got=%h exp=%h", r, rom_addr, 32'h0); end
      total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL mis_valid[%0d] got=%h exp=%h", r, if_valid, 1'b0); end
      tick();
    end
    branch_flag = 1'b1;
    branch_target_addr = 32'h0000_0200;
    tick();
    branch_flag = 1'b0;
    total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL mis_clear got=%h exp=%h", misalign_err, 1'b0); end
    total++; if (rom_ce !== 1'b1) begin bad++; $display("[TB] FAIL mis_resume_ce got=%h exp=%h", rom_ce, 1'b1); end
    total++; if (rom_addr !== 32'h200) begin bad++; $display("[TB] FAIL mis_resume_addr got=%h exp=%h", rom_addr, 32'h200); end
    tick();
    total++; if (if_valid !== 1'b1) begin bad++; $display("[TB] FAIL mis_resume_valid got=%h exp=%h", if_valid, 1'b1); end
    total++; if (if_pc !== 32'h200) begin bad++; $display("[TB] FAIL mis_resume_pc got=%h exp=%h", if_pc, 32'h200); end
    total++; if (if_inst !== 32'h80) begin bad++; $display("[TB] FAIL mis_resume_inst got=%h exp=%h", if_inst, 32'h80); end
  endtask

  task automatic test_stall();
    fill_to_hold();
    stall = 1'b1;
    if_ready = 1'b1;
    total++; if (if_pc !== 32'h0) begin bad++; $display("[TB] FAIL stall_drain0 got=%h exp=%h", if_pc, 32'h0); end
    tick();
    total++; if (if_pc !== 32'h4) begin bad++; $display("[TB] FAIL stall_drain1 got=%h exp=%h", if_pc, 32'h4); end
    tick();
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_empty got=%h exp=%h", if_valid, 1'b0); end
    total++; if (rom_addr !== 32'h8) begin bad++; $display("[TB] FAIL stall_pc_frozen got=%h exp=%h", rom_addr, 32'h8); end
    tick();
    stall = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_release_valid got=%h exp=%h", if_valid, 1'b0); end
    tick();
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_resume_early got=%h exp=%h", if_valid, 1'b0); end
    total++; if (rom_addr !== 32'h8) begin bad++; $display("[TB] FAIL stall_resume_addr got=%h exp=%h", rom_addr, 32'h8); end
    tick();
    total++; if (if_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_resume_valid got=%h exp=%h", if_valid, 1'b1); end
    total++; if (if_pc !== 32'h8) begin bad++; $display("[TB] FAIL stall_resume_pc got=%h exp=%h", if_pc, 32'h8); end
    total++; if (if_inst !== 32'h2) begin bad++; $display("[TB] FAIL stall_resume_inst got=%h exp=%h", if_inst, 32'h2); end
    tick();
    total++; if (if_pc !== 32'hC) begin bad++; $display("[TB] FAIL stall_next_pc got=%h exp=%h", if_pc, 32'hC); end
  endtask

  task automatic test_mid_reset();
    fill_to_hold();
    rst = 1'b0;
    #2;
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL mrst_valid got=%h exp=%h", if_valid, 1'b0); end
    total++; if (rom_ce !== 1'b0) begin bad++; $display("[TB] FAIL mrst_rom_ce got=%h exp=%h", rom_ce, 1'b0); end
    total++; if (rom_addr !== 32'h0) begin bad++; $display("[TB] FAIL mrst_rom_addr got=%h exp=%h", rom_addr, 32'h0); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("[TB] FAIL mrst_if_pc got=%h exp=%h", if_pc, 32'h0); end
    total++; if (if_inst !== 32'h0) begin bad++; $display("[TB] FAIL mrst_if_inst got=%h exp=%h", if_inst, 32'h0); end
    tick();
    rst = 1'b1;
    branch_flag = 1'b1;
    branch_target_addr = 32'h0000_0300;
    total++; if (rom_ce !== 1'b0) begin bad++; $display("[TB] FAIL mrst_idle_ce got=%h exp=%h", rom_ce, 1'b0); end
    tick();
    branch_flag = 1'b0;
    total++; if (rom_addr !== 32'h0) begin bad++; $display("[TB] FAIL idle_branch_ignored got=%h exp=%h", rom_addr, 32'h0); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL mrst_discard got=%h exp=%h", if_valid, 1'b0); end
    if_ready = 1'b1;
    tick();
    total++; if (if_pc !== 32'h0) begin bad++; $display("[TB] FAIL mrst_first_pc got=%h exp=%h", if_pc, 32'h0); end
    total++; if (if_valid !== 1'b1) begin bad++; $display("[TB] FAIL mrst_first_valid got=%h exp=%h", if_valid, 1'b1); end
  endtask

  task automatic test_wrap();
    rst = 1'b0;
    stall = 1'b0;
    branch_flag = 1'b0;
    if_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    tick();
    total++; if (w_if_pc !== 32'hFFFF_FFF8) begin bad++; $display("[TB] FAIL wrap_pc0 got=%h exp=%h", w_if_pc, 32'hFFFF_FFF8); end
    total++; if (w_if_inst !== 32'h3FFF_FFFE) begin bad++; $display("[TB] FAIL wrap_inst0 got=%h exp=%h", w_if_inst, 32'h3FFF_FFFE); end
    tick();
    total++; if (w_if_pc !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_pc1 got=%h exp=%h", w_if_pc, 32'hFFFF_FFFC); end
    total++; if (w_if_inst !== 32'h3FFF_FFFF) begin bad++; $display("[TB] FAIL wrap_inst1 got=%h exp=%h", w_if_inst, 32'h3FFF_FFFF); end
    tick();
    total++; if (w_if_valid !== 1'b1) begin bad++; $display("[TB] FAIL wrap_valid2 got=%h exp=%h", w_if_valid, 1'b1); end
    total++; if (w_if_pc !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc2 got=%h exp=%h", w_if_pc, 32'h0); end
    total++; if (w_if_inst !== 32'h0) begin bad++; $display("[TB] FAIL wrap_inst2 got=%h exp=%h", w_if_inst, 32'h0); end
  endtask

  // Run every scenario in order, then report
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_stall();
    test_mid_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the fetch-buffer entry count (legal values 2 or 4).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  pipeline stall; no new fetch while high.
REQ-006 branch_flag  in  1  redirect request.
REQ-007 branch_target_addr  in  32  redirect byte address.
REQ-008 rom_ce  out  1  instruction-ROM chip enable; 1 = enabled.
REQ-009 rom_addr  out  32  instruction-ROM byte address.
REQ-010 rom_inst  in  32  ROM read data, combinational from rom_addr.
REQ-011 if_valid  out  1  buffer head holds a valid instruction.
REQ-012 if_ready  in  1  consumer accepts head this cycle.
REQ-013 if_pc  out  32  byte address of head instruction.
REQ-014 if_inst  out  32  head instruction word.
REQ-015 misalign_err  out  1  sticky redirect-misalignment flag.

Function
REQ-016 States IDLE, FETCH, HOLD, ERR; registered pc (32 bit) and FIFO of BUF_DEPTH {pc,inst} entries with count.
REQ-017 IDLE: rom_ce=0, rom_addr=0, no push; unconditional transition to FETCH next cycle.
REQ-018 FETCH/HOLD: rom_ce=1, rom_addr=pc.
REQ-019 Push condition: state FETCH, stall=0, branch_flag=0, and (count<BUF_DEPTH or pop this cycle); on push, entry {pc, rom_inst} is written and pc<=pc+4, wrapping modulo 2^32.
REQ-020 FETCH->HOLD when stall=1 or buffer full without pop; HOLD->FETCH when stall=0 and space exists; pc held in HOLD.
REQ-021 Pop when if_valid && if_ready; if_valid = (count!=0); if_pc/if_inst show the head entry and are 0 when empty.
REQ-022 Latency: instruction at address A is presented on if_valid the cycle after A is driven on rom_addr.
REQ-023 Simultaneous push and pop: count unchanged, FIFO order preserved.
REQ-024 Redirect (branch_flag=1) has highest priority in any state except IDLE: FIFO flushed (count<=0), any same-cycle pop and push discarded, pc<=branch_target_addr.
REQ-025 Redirect with branch_target_addr[1:0]==0: next state FETCH, misalign_err cleared.
REQ-026 Redirect with branch_target_addr[1:0]!=0: next state ERR, misalign_err<=1.
REQ-027 ERR: rom_ce=0, rom_addr=0, no push, if_valid=0; exits only via aligned redirect (REQ-025) or reset.
REQ-028 branch_flag during IDLE is ignored.
REQ-029 stall does not block pops; the consumer may drain the buffer while stalled.

Reset
REQ-030 rst low asynchronously forces: state IDLE, pc=RESET_PC, count=0, FIFO pointers 0, misalign_err=0, rom_ce=0, rom_addr=0, if_valid=0, if_pc=0, if_inst=0.
REQ-031 Reset asserted mid-fetch discards all buffered entries; first fetch after release is RESET_PC, beginning the second rising edge after release.

Verification
REQ-032 Reset release, if_ready=1, ROM word n = n -> cycle 1 rom_ce=0; then if_pc 0,4,8,... with if_inst 0,1,2,... one per cycle.
REQ-033 if_ready=0 for 5 cycles -> exactly BUF_DEPTH entries (pc 0,4) buffered, HOLD, pc=8; on if_ready=1 order 0,4,8 is kept with no duplicate or loss.
REQ-034 Redirect to 32'h0000_0100 while 2 entries buffered and if_ready=1 -> next cycle if_valid=0; following cycle if_pc=32'h100.
REQ-035 Redirect to 32'h0000_0102 -> misalign_err=1, rom_ce=0, if_valid=0 held; later redirect to 32'h0000_0200 clears flag, fetch resumes at 32'h200.
REQ-036 RESET_PC=32'hFFFF_FFF8, free-running -> if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
REQ-037 stall=1 for 3 cycles with entries buffered and if_ready=1 -> buffer drains, no new pushes, pc frozen; fetch resumes one cycle after stall=0.
